// File: rtl/vector_writeback.sv
// vector_writeback: turns vector ALU result beats into register-file writes with vl/v0/tail strobes.
// Build option VWB_OUTPUT_REG_EN registers the write port and delays done_o to match.
package vector_writeback_pkg;
  typedef enum logic [2:0] {
    LMUL_1   = 3'b000,
    LMUL_2   = 3'b001,
    LMUL_4   = 3'b010,
    LMUL_8   = 3'b011,
    LMUL_1_8 = 3'b101,
    LMUL_1_4 = 3'b110,
    LMUL_1_2 = 3'b111
  } vlmul_e;

  typedef enum logic [1:0] {
    EW8  = 2'b00,
    EW16 = 2'b01,
    EW32 = 2'b10,
    EW64 = 2'b11
  } vew_e;
endpackage

// state  | meaning
// IDLE   | waiting for start_i
// DATA   | one register write per result beat
// MASK   | counting beats, single mask write on the last one
// FINISH | done_o pulse, back to IDLE
module vector_writeback
  import vector_writeback_pkg::*;
#(
  parameter int VLEN  = 64,
  parameter int VLENB = VLEN / 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [4:0]             vd_i,
  input  vlmul_e                 vlmul_i,
  input  vew_e                   vsew_i,
  input  logic [$clog2(VLEN):0]  vl_i,
  input  logic                   vm_i,
  input  logic [VLEN-1:0]        v0_i,
  input  logic                   widening_i,
  input  logic                   mask_dest_i,
  input  logic                   result_valid_i,
  input  logic [VLEN-1:0]        result_i,
  input  logic [VLEN-1:0]        result_mask_i,
  output logic                   wr_en_o,
  output logic [4:0]             wr_addr_o,
  output logic [VLEN-1:0]        wr_data_o,
  output logic [VLENB-1:0]       wr_strb_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int AW  = $clog2(VLEN);
  localparam int VLW = AW + 1;
  localparam int IW  = AW + 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_MASK,
    S_FINISH
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       beat_q, beat_d;
  logic [4:0]       grp_q, grp_d;
  logic [4:0]       vd_q, vd_d;
  logic [2:0]       esh_q, esh_d;
  logic [VLW-1:0]   vl_q, vl_d;
  logic             vm_q, vm_d;
  logic [VLEN-1:0]  v0_q, v0_d;

  logic             wr_en_d;
  logic [4:0]       wr_addr_d;
  logic [VLEN-1:0]  wr_data_d;
  logic [VLENB-1:0] wr_strb_d;
  logic             done_d;

  logic [4:0]       grp_start;
  logic [2:0]       esh_start;
  logic             last_beat;
  logic [VLENB-1:0] data_strb;
  logic [VLEN-1:0]  mask_data;
  logic [IW-1:0]    byte_idx;
  logic [IW-1:0]    elem_idx;

  always_comb begin
    grp_start = 5'd1;
    case (vlmul_i)
      LMUL_2:  grp_start = 5'd2;
      LMUL_4:  grp_start = 5'd4;
      LMUL_8:  grp_start = 5'd8;
      default: grp_start = 5'd1;
    endcase
    if (widening_i) grp_start = grp_start << 1;

    esh_start = 3'd0;
    case (vsew_i)
      EW16:    esh_start = 3'd1;
      EW32:    esh_start = 3'd2;
      EW64:    esh_start = 3'd3;
      default: esh_start = 3'd0;
    endcase
    if (widening_i) esh_start = esh_start + 3'd1;
  end

  // Element sizes are powers of two, so byte->element is a right shift by esh_q.
  always_comb begin
    data_strb = '0;
    byte_idx  = '0;
    elem_idx  = '0;
    for (int b = 0; b < VLENB; b++) begin
      byte_idx     = IW'(beat_q) * IW'(VLENB) + IW'(b);
      elem_idx     = byte_idx >> esh_q;
      data_strb[b] = (elem_idx < IW'(vl_q)) && (vm_q || v0_q[elem_idx[AW-1:0]]);
    end
  end

  always_comb begin
    mask_data = '1;
    for (int i = 0; i < VLEN; i++) begin
      if ((VLW'(i) < vl_q) && (vm_q || v0_q[i])) mask_data[i] = result_mask_i[i];
    end
  end

  assign last_beat = (beat_q == (grp_q - 5'd1));

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    grp_d     = grp_q;
    vd_d      = vd_q;
    esh_d     = esh_q;
    vl_d      = vl_q;
    vm_d      = vm_q;
    v0_d      = v0_q;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    wr_strb_d = '0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          vd_d    = vd_i;
          grp_d   = grp_start;
          esh_d   = esh_start;
          vl_d    = vl_i;
          vm_d    = vm_i;
          v0_d    = v0_i;
          beat_d  = '0;
          state_d = mask_dest_i ? S_MASK : S_DATA;
        end
      end
      S_DATA: begin
        if (result_valid_i) begin
          wr_en_d   = 1'b1;
          wr_addr_d = vd_q + beat_q;
          wr_data_d = result_i;
          wr_strb_d = data_strb;
          beat_d    = beat_q + 5'd1;
          if (last_beat) state_d = S_FINISH;
        end
      end
      S_MASK: begin
        if (result_valid_i) begin
          beat_d = beat_q + 5'd1;
          if (last_beat) begin
            wr_en_d   = 1'b1;
            wr_addr_d = vd_q;
            wr_data_d = mask_data;
            wr_strb_d = '1;
            state_d   = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        beat_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      grp_q   <= '0;
      vd_q    <= '0;
      esh_q   <= '0;
      vl_q    <= '0;
      vm_q    <= 1'b0;
      v0_q    <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      grp_q   <= grp_d;
      vd_q    <= vd_d;
      esh_q   <= esh_d;
      vl_q    <= vl_d;
      vm_q    <= vm_d;
      v0_q    <= v0_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);

`ifdef VWB_OUTPUT_REG_EN
  logic             wr_en_q;
  logic [4:0]       wr_addr_q;
  logic [VLEN-1:0]  wr_data_q;
  logic [VLENB-1:0] wr_strb_q;
  logic             done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      done_q    <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_strb_q <= wr_strb_d;
      done_q    <= done_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign wr_strb_o = wr_strb_q;
  assign done_o    = done_q;
`else
  assign wr_en_o   = wr_en_d;
  assign wr_addr_o = wr_addr_d;
  assign wr_data_o = wr_data_d;
  assign wr_strb_o = wr_strb_d;
  assign done_o    = done_d;
`endif

endmodule

// File: tb/tb_vector_writeback.sv
// Bench for vector_writeback: scripted and random instructions checked each cycle against a behavioural model.
module tb_vector_writeback;
  import vector_writeback_pkg::*;

  localparam int VLEN  = 64;
  localparam int VLENB = 8;
`ifdef VWB_OUTPUT_REG_EN
  localparam bit LAT = 1'b1;
`else
  localparam bit LAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start_i;
  logic [4:0]       vd_i;
  vlmul_e           vlmul_i;
  vew_e             vsew_i;
  logic [6:0]       vl_i;
  logic             vm_i;
  logic [VLEN-1:0]  v0_i;
  logic             widening_i;
  logic             mask_dest_i;
  logic             result_valid_i;
  logic [VLEN-1:0]  result_i;
  logic [VLEN-1:0]  result_mask_i;
  logic             wr_en_o;
  logic [4:0]       wr_addr_o;
  logic [VLEN-1:0]  wr_data_o;
  logic [VLENB-1:0] wr_strb_o;
  logic             busy_o;
  logic             done_o;

  vector_writeback #(.VLEN(VLEN), .VLENB(VLENB)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .vd_i(vd_i), .vlmul_i(vlmul_i),
    .vsew_i(vsew_i), .vl_i(vl_i), .vm_i(vm_i), .v0_i(v0_i), .widening_i(widening_i),
    .mask_dest_i(mask_dest_i), .result_valid_i(result_valid_i), .result_i(result_i),
    .result_mask_i(result_mask_i), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .wr_strb_o(wr_strb_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic        done;
    logic        busy;
  } exp_t;

  exp_t cur;
  exp_t prev;
  int   n_vec = 0;
  int   n_err = 0;
  bit   checking = 1'b0;

  vlmul_e lm_tab[7] = '{LMUL_1_8, LMUL_1_4, LMUL_1_2, LMUL_1, LMUL_2, LMUL_4, LMUL_8};
  vew_e   ew_tab[3] = '{EW8, EW16, EW32};

  function automatic int grp(input vlmul_e l, input bit w);
    int g;
    case (l)
      LMUL_2:  g = 2;
      LMUL_4:  g = 4;
      LMUL_8:  g = 8;
      default: g = 1;
    endcase
    return w ? 2 * g : g;
  endfunction

  function automatic logic [7:0] model_strb(input int k, input vew_e sew, input bit wide,
                                            input int vl, input bit vm, input logic [63:0] v0);
    int e;
    int elem;
    logic [7:0] s;
    case (sew)
      EW8:     e = 1;
      EW16:    e = 2;
      EW32:    e = 4;
      default: e = 8;
    endcase
    if (wide) e = e * 2;
    s = '0;
    for (int b = 0; b < VLENB; b++) begin
      elem = (k * VLENB + b) / e;
      s[b] = (elem < vl) && (vm || v0[elem]);
    end
    return s;
  endfunction

  function automatic logic [63:0] model_mask(input int vl, input bit vm, input logic [63:0] v0,
                                             input logic [63:0] rm);
    logic [63:0] m;
    for (int i = 0; i < VLEN; i++) m[i] = ((i < vl) && (vm || v0[i])) ? rm[i] : 1'b1;
    return m;
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  function automatic void pin(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    chk(name, act, exp);
  endfunction

  always @(posedge clk) prev <= cur;

  always @(negedge clk) begin : compare
    exp_t e;
    if (checking) begin
      e      = LAT ? prev : cur;
      e.busy = cur.busy;
      if (reset) e = '0;
      n_vec++;
      chk("wr_en", 64'(wr_en_o), 64'(e.en));
      chk("done", 64'(done_o), 64'(e.done));
      chk("busy", 64'(busy_o), 64'(e.busy));
      if (e.en || reset) begin
        chk("wr_addr", 64'(wr_addr_o), 64'(e.addr));
        chk("wr_data", wr_data_o, e.data);
        chk("wr_strb", 64'(wr_strb_o), 64'(e.strb));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic en, input logic [4:0] a, input logic [63:0] d,
                         input logic [7:0] s, input logic dn, input logic b);
    cur.en   = en;
    cur.addr = a;
    cur.data = d;
    cur.strb = s;
    cur.done = dn;
    cur.busy = b;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic scramble();
    vd_i        = 5'($urandom_range(0, 31));
    vlmul_i     = lm_tab[$urandom_range(0, 6)];
    vsew_i      = ew_tab[$urandom_range(0, 2)];
    vl_i        = 7'($urandom_range(0, 64));
    vm_i        = 1'($urandom_range(0, 1));
    v0_i        = rnd64();
    widening_i  = 1'($urandom_range(0, 1));
    mask_dest_i = 1'($urandom_range(0, 1));
  endtask

  task automatic run_instr(input vlmul_e lmul, input vew_e sew, input bit wide, input bit mdest,
                           input logic [4:0] vd, input logic [6:0] vl, input bit vm,
                           input logic [63:0] v0, input logic [63:0] rmask,
                           input int rst_beat, input bit gaps);
    int g;
    int n;
    logic [63:0] d;
    g = grp(lmul, wide);
    start_i = 1'b1;  vd_i = vd;  vlmul_i = lmul;  vsew_i = sew;  vl_i = vl;  vm_i = vm;
    v0_i = v0;  widening_i = wide;  mask_dest_i = mdest;  result_mask_i = rmask;
    result_valid_i = 1'($urandom_range(0, 1));
    result_i = rnd64();
    set_exp(1'b0, '0, '0, '0, 1'b0, 1'b0);
    tick();
    start_i = 1'b0;
    scramble();
    for (int k = 0; k < g; k++) begin
      n = gaps ? $urandom_range(0, 2) : 0;
      for (int j = 0; j < n; j++) begin
        result_valid_i = 1'b0;
        start_i = 1'($urandom_range(0, 1));
        result_i = rnd64();
        set_exp(1'b0, '0, '0, '0, 1'b0, 1'b1);
        tick();
      end
      if (k == rst_beat) begin
        reset = 1'b1;  result_valid_i = 1'b1;  start_i = 1'b0;
        set_exp(1'b0, '0, '0, '0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;  result_valid_i = 1'b0;
        tick();
        return;
      end
      result_valid_i = 1'b1;
      start_i = 1'($urandom_range(0, 1));
      d = rnd64();
      result_i = d;
      if (mdest) begin
        if (k == g - 1) set_exp(1'b1, vd, model_mask(int'(vl), vm, v0, rmask), 8'hFF, 1'b0, 1'b1);
        else            set_exp(1'b0, '0, '0, '0, 1'b0, 1'b1);
      end else begin
        set_exp(1'b1, 5'((int'(vd) + k) % 32), d, model_strb(k, sew, wide, int'(vl), vm, v0), 1'b0, 1'b1);
      end
      tick();
    end
    result_valid_i = 1'($urandom_range(0, 1));
    start_i = 1'($urandom_range(0, 1));
    set_exp(1'b0, '0, '0, '0, 1'b1, 1'b1);
    tick();
    start_i = 1'b0;
    n = gaps ? $urandom_range(0, 2) : 0;
    for (int j = 0; j < n; j++) begin
      result_valid_i = 1'($urandom_range(0, 1));
      result_i = rnd64();
      set_exp(1'b0, '0, '0, '0, 1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    vlmul_e lm;
    bit     wd;
    int     g;
    reset = 1'b1;  start_i = 1'b0;  vd_i = '0;  vlmul_i = LMUL_1;  vsew_i = EW8;  vl_i = '0;
    vm_i = 1'b1;  v0_i = '0;  widening_i = 1'b0;  mask_dest_i = 1'b0;  result_valid_i = 1'b0;
    result_i = '0;  result_mask_i = '0;
    cur = '0;
    checking = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();

    pin("pin_strb_ew8_vl5", 64'(model_strb(0, EW8, 1'b0, 5, 1'b1, 64'h0)), 64'h1F);
    pin("pin_strb_ew32_beat3", 64'(model_strb(3, EW32, 1'b0, 7, 1'b1, 64'h0)), 64'h0F);
    pin("pin_strb_ew16_v0", 64'(model_strb(0, EW16, 1'b0, 4, 1'b0, 64'hA)), 64'hCC);
    pin("pin_strb_wide_beat3", 64'(model_strb(3, EW8, 1'b1, 16, 1'b1, 64'h0)), 64'hFF);
    pin("pin_mask_data", model_mask(10, 1'b1, 64'h0, 64'h3A5), 64'hFFFF_FFFF_FFFF_FFA5);
    pin("pin_grp_wide_lmul2", 64'(grp(LMUL_2, 1'b1)), 64'd4);

    run_instr(LMUL_1, EW8,  1'b0, 1'b0, 5'd3,  7'd5,  1'b1, 64'h0, 64'h0, -1, 1'b0);
    run_instr(LMUL_4, EW32, 1'b0, 1'b0, 5'd8,  7'd7,  1'b1, 64'h0, 64'h0, -1, 1'b0);
    run_instr(LMUL_1, EW16, 1'b0, 1'b0, 5'd0,  7'd4,  1'b0, 64'hA, 64'h0, -1, 1'b0);
    run_instr(LMUL_2, EW8,  1'b1, 1'b0, 5'd4,  7'd16, 1'b1, 64'h0, 64'h0, -1, 1'b0);
    run_instr(LMUL_2, EW8,  1'b0, 1'b1, 5'd2,  7'd10, 1'b1, 64'h0, 64'h3A5, -1, 1'b0);
    run_instr(LMUL_4, EW8,  1'b0, 1'b0, 5'd16, 7'd32, 1'b1, 64'h0, 64'h0, 2, 1'b0);
    run_instr(LMUL_8, EW16, 1'b0, 1'b0, 5'd24, 7'd0,  1'b0, rnd64(), 64'h0, -1, 1'b1);
    run_instr(LMUL_4, EW8,  1'b0, 1'b1, 5'd8,  7'd0,  1'b1, 64'h0, rnd64(), -1, 1'b1);

    for (int t = 0; t < 250; t++) begin
      lm = lm_tab[$urandom_range(0, 6)];
      wd = (lm != LMUL_8) ? 1'($urandom_range(0, 1)) : 1'b0;
      g  = grp(lm, wd);
      run_instr(lm, ew_tab[$urandom_range(0, 2)], wd, ($urandom_range(0, 3) == 0),
                5'($urandom_range(0, 31)) & ~5'(g - 1),
                ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 64)),
                1'($urandom_range(0, 1)), rnd64(), rnd64(),
                ($urandom_range(0, 19) == 0) ? $urandom_range(0, g - 1) : -1, 1'b1);
    end

    set_exp(1'b0, '0, '0, '0, 1'b0, 1'b0);
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vector_writeback.md
# vector_writeback

Vector result write-back stage placed directly downstream of the vector ALU. It collects the per-cycle result beats of one vector instruction and converts each beat into a register-file write:
- destination register index within the LMUL group;
- per-byte write strobes that enforce vl, tail-undisturbed and v0 masking;
- for mask-producing instructions, a single final write of the assembled mask register.

It signals instruction completion to the vector control unit.

## Interface
Parameters:
- VLEN, 64, vector register width in bits
- VLENB, 8, VLEN/8, bytes per register

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle pulse; latches instruction fields below
- vd_i  in  5  destination base register (group-aligned)
- vlmul_i  in  vlmul_e  register group multiplier
- vsew_i  in  vew_e  source element width (EW8/EW16/EW32)
- vl_i  in  $clog2(VLEN)+1  active vector length in elements
- vm_i  in  1  1 = unmasked; 0 = masked by v0
- v0_i  in  VLEN  contents of v0
- widening_i  in  1  destination EEW = 2*SEW, group doubled
- mask_dest_i  in  1  instruction produces a mask register
- result_valid_i  in  1  one result beat present this cycle
- result_i  in  VLEN  data beat
- result_mask_i  in  VLEN  accumulated mask result
- wr_en_o  out  1  register-file write enable
- wr_addr_o  out  5  register index
- wr_data_o  out  VLEN  write data
- wr_strb_o  out  VLENB  byte write strobes
- busy_o  out  1  instruction in progress
- done_o  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, DATA, MASK, FINISH.
- IDLE, start_i=1:
  - latch all instruction fields;
  - beat counter = 0;
  - go to MASK if mask_dest_i, else DATA.
- Group size G:
  - LMUL_1_8, LMUL_1_4, LMUL_1_2, LMUL_1 → 1;
  - LMUL_2 → 2, LMUL_4 → 4, LMUL_8 → 8;
  - widening_i doubles G.
  - Widening with LMUL_8 never occurs; control guarantees this.
- DATA, on each result_valid_i:
  - wr_en_o=1, wr_addr_o=(vd+beat) mod 32, wr_data_o=result_i;
  - beat counter increments;
  - after the beat with index G-1, go to FINISH.
- Strobes, for beat k and byte b:
  - E = destination element bytes (SEW bytes, or 2*SEW bytes if widening);
  - elem = (k*VLENB+b)/E;
  - strb[b] = (elem < vl) && (vm || v0[elem]);
  - tail and inactive bytes are left undisturbed.
- MASK state:
  - count result_valid_i beats up to G;
  - on the G-th beat, write vd with wr_strb_o all ones;
  - bit i of the write data = result_mask_i[i] if i<vl and (vm || v0[i]), else 1 (mask-agnostic);
  - then go to FINISH.
- FINISH: done_o=1 for one cycle, then go to IDLE.
- start_i while not IDLE: ignored.
- result_valid_i in IDLE or FINISH: ignored, no write.
- vl=0: all beats are still consumed. DATA writes carry strb=0. MASK writes all ones.

## Timing
- Reset values: wr_en_o=0, wr_addr_o=0, wr_data_o=0, wr_strb_o=0, busy_o=0, done_o=0, FSM=IDLE, counters 0.
- busy_o is high from the cycle after start_i through FINISH inclusive.
- Write outputs are combinational from result_valid_i, giving same-cycle latency (see Configuration).
- done_o is asserted the cycle after the last write is presented.
- Reset asserted mid-instruction:
  - immediate abort, state returns to reset values;
  - no done_o pulse;
  - any partial group is not completed.
- Back-to-back: start_i is accepted in the cycle after done_o.

## Configuration
- VWB_OUTPUT_REG_EN defined:
  - wr_en_o, wr_addr_o, wr_data_o and wr_strb_o are registered, adding one cycle of latency;
  - done_o is delayed one cycle so it stays one cycle after the registered last write.
- VWB_OUTPUT_REG_EN undefined: write outputs are combinational, same cycle as result_valid_i.

## Test plan
- VLEN=64, LMUL_1, EW8, vl=5, vm=1, vd=3, one beat of 0x1122334455667788:
  - write addr 3, strb=0x1F, data unchanged;
  - done_o one cycle later.
- LMUL_4, EW32, vl=7, vm=1, vd=8, four beats:
  - addrs 8,9,10,11;
  - strbs 0xFF,0xFF,0xFF,0x0F.
- EW16, vm=0, v0=0b1010, vl=4, one beat:
  - strb=0xCC (elements 1 and 3 only).
- Widening, LMUL_2, EW8, vl=16, vd=4:
  - G=4, addrs 4–7, E=2 bytes;
  - all strbs 0xFF.
- mask_dest_i, LMUL_2, vl=10, vm=1, result_mask_i=0x3A5:
  - single write to vd after the 2nd beat, strb 0xFF;
  - data = 0xFFFF_FFFF_FFFF_FFA5 for bits 0–9 of 0x3A5 plus ones in the tail; the 0xFFFF_FFFF_FFFF_FC00 | 0x3A5 form is an equivalent check;
  - done_o on the following cycle.
- Reset pulse during beat 2 of a LMUL_4 instruction:
  - outputs zero immediately, no done_o;
  - next start_i accepted normally.
